// File: rtl/adc_if_trace_capture.sv
// adc_if_trace_capture: circular trace buffer for the ADC interface debug path.
// Captures NCH concatenated W-bit probe words into a DEPTH-entry ring. A
// capture keeps a programmable number of pre-trigger samples, then fills the
// rest of the ring after a mask/value or external trigger.
// Optional build macro TRACE_TIMESTAMP_EN stores a free-running cycle stamp
// with every entry and adds the rd_ts/trig_ts outputs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no capture since reset; waits for arm
// S_PRE   | filling the first pt pre-trigger entries, trigger not evaluated
// S_ARMED | ring keeps rolling, every valid sample is trigger-compared
// S_POST  | trigger seen, filling the remaining DEPTH-pt entries
// S_DONE  | capture complete, buffer coherent for readback; arm restarts
module adc_if_trace_capture #(
  parameter int NCH   = 2,
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
`ifdef TRACE_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*W-1:0]     probe_in,
  input  logic                 probe_valid,
  input  logic                 arm,
  input  logic [AW-1:0]        pretrig,
  input  logic [NCH*W-1:0]     trig_mask,
  input  logic [NCH*W-1:0]     trig_value,
  input  logic                 ext_trig,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic [AW-1:0]        start_addr,
  output logic [AW-1:0]        trig_addr,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]      rd_ts,
  output logic [TS_W-1:0]      trig_ts,
`endif
  output logic [NCH*W-1:0]     rd_data,
  output logic                 rd_valid
);

  localparam int EW = NCH * W;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PT_MAX  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   pt_q;
  logic [AW-1:0]   pre_cnt_q;
  logic [AW:0]     post_cnt_q;
  logic            busy_q;
  logic            triggered_q;
  logic            done_q;
  logic [AW-1:0]   start_addr_q;
  logic [AW-1:0]   trig_addr_q;
  logic [EW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [EW-1:0]   mem [DEPTH];

  logic            capturing;
  logic            wr_en;
  logic            hit;
  logic [AW-1:0]   pt_d;
  logic [AW-1:0]   pre_cnt_d;
  logic [AW:0]     post_cnt_d;
  logic [AW:0]     post_target;
  logic [AW-1:0]   rd_phys;

  // Write qualification, trigger compare and derived counts.
  always_comb begin
    capturing   = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    // rst_n gates the write so a reset cycle mid-capture never touches memory.
    wr_en       = rst_n && probe_valid && capturing;
    hit         = probe_valid && ((((probe_in ^ trig_value) & trig_mask) == '0) || ext_trig);
    pt_d        = ({1'b0, pretrig} > {1'b0, PT_MAX}) ? PT_MAX : pretrig;
    pre_cnt_d   = pre_cnt_q + 1'b1;
    post_cnt_d  = post_cnt_q + 1'b1;
    post_target = DEPTH_W - {1'b0, pt_q};
    rd_phys     = start_addr_q + rd_addr;
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] trig_ts_q;
  logic [TS_W-1:0] rd_ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Free-running wrapping cycle stamp.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end
`endif

  // Capture sequencer; all status outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wp_q         <= '0;
      pt_q         <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      trig_addr_q  <= '0;
`ifdef TRACE_TIMESTAMP_EN
      trig_ts_q    <= '0;
`endif
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            pt_q        <= pt_d;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (pt_d == '0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          if (probe_valid) begin
            pre_cnt_q <= pre_cnt_d;
            if (pre_cnt_d == pt_q) state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (hit) begin
            trig_addr_q  <= wp_q;
            start_addr_q <= wp_q - pt_q;
            triggered_q  <= 1'b1;
            post_cnt_q   <= (AW+1)'(1);
`ifdef TRACE_TIMESTAMP_EN
            trig_ts_q    <= ts_q;
`endif
            // With pt = DEPTH-1 the trigger entry alone completes the ring.
            if (post_target == (AW+1)'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (probe_valid) begin
            post_cnt_q <= post_cnt_d;
            if (post_cnt_d == post_target) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Single write port into the ring (block RAM, contents not reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= probe_in;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wp_q] <= ts_q;
`endif
    end
  end

  // Registered read port, logical index rebased on the oldest entry; read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      rd_ts_q    <= '0;
`endif
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_phys];
`ifdef TRACE_TIMESTAMP_EN
        rd_ts_q   <= ts_mem[rd_phys];
`endif
      end
    end
  end

  assign busy       = busy_q;
  assign triggered  = triggered_q;
  assign done       = done_q;
  assign start_addr = start_addr_q;
  assign trig_addr  = trig_addr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts      = rd_ts_q;
  assign trig_ts    = trig_ts_q;
`endif

endmodule

// File: tb/tb_adc_if_trace_capture.sv
// Bench for adc_if_trace_capture (DEPTH=16). The reference model records every
// sample accepted after arm as a list and derives the expected ring image,
// trigger/start addresses and status flags from the capture rules.
module tb_adc_if_trace_capture;
  localparam int NCH  = 2;
  localparam int W    = 8;
  localparam int D    = 16;
  localparam int AW   = 4;
  localparam int EW   = NCH * W;
  localparam int TS_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, probe_valid, arm, ext_trig, rd_en;
  logic [EW-1:0] probe_in, trig_mask, trig_value;
  logic [AW-1:0] pretrig, rd_addr;
  logic          busy, triggered, done, rd_valid;
  logic [AW-1:0] start_addr, trig_addr;
  logic [EW-1:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] rd_ts, trig_ts;
`endif

  adc_if_trace_capture #(.NCH(NCH), .W(W), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .probe_in(probe_in), .probe_valid(probe_valid),
    .arm(arm), .pretrig(pretrig), .trig_mask(trig_mask), .trig_value(trig_value),
    .ext_trig(ext_trig), .busy(busy), .triggered(triggered), .done(done),
    .start_addr(start_addr), .trig_addr(trig_addr), .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts), .trig_ts(trig_ts),
`endif
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  int              n_checks = 0;
  int              n_err    = 0;
  logic [TS_W-1:0] tb_ts;
  int              wp_model;
  bit              have_prev;
  logic [EW-1:0]   prev_oldest;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge. tb_ts mirrors the
  // expected stamp counter (cleared by a reset edge, else +1).
  task automatic cyc();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) tb_ts = '0;
    else    tb_ts = tb_ts + 1'b1;
  endtask

  task automatic idle_inputs();
    probe_valid = 1'b0; arm = 1'b0; ext_trig = 1'b0; rd_en = 1'b0;
  endtask

  // mode 0: ch0 = cycle counter every cycle, mode 1: random,
  // mode 2: valid on even cycles with a matching value shown on invalid cycles,
  // mode 3: ch0 counter with ext_trig on the 3rd valid sample.
  task automatic run_capture(input int mode, input int pre,
                             input logic [EW-1:0] mask, input logic [EW-1:0] value);
    logic [EW-1:0]   smp[$];
    logic [TS_W-1:0] sts[$];
    int pt, trig, wp0, n;
    bit complete, v, e;
    logic [EW-1:0] p;
    pt = (pre > D-1) ? D-1 : pre;
    wp0 = wp_model; trig = -1; complete = 1'b0;
    trig_mask = mask; trig_value = value; pretrig = AW'(pre);
    arm = 1'b1; probe_valid = 1'b0; ext_trig = 1'b0;
    if (have_prev) begin rd_en = 1'b1; rd_addr = '0; end
    cyc();
    arm = 1'b0;
    if (have_prev) begin
      check("arm_rd_valid", rd_valid, 1);
      check("arm_rd_old_map", rd_data, prev_oldest);
    end
    rd_en = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_trig_clr", triggered, 0);
    check("arm_done_clr", done, 0);
    for (int c = 0; c < 400 && !complete; c++) begin
      n = smp.size();
      case (mode)
        0: begin v = 1'b1; p = {8'($urandom), 8'(c)}; e = 1'b0; end
        1: begin v = ($urandom % 4) != 0; p = EW'($urandom); e = ($urandom % 16) == 0; end
        2: begin
          v = (c % 2) == 0;
          p = !v ? value : ((n == pt + 3) ? value : (value ^ EW'(1)));
          e = 1'b0;
        end
        default: begin v = 1'b1; p = EW'(c); e = (n == 2); end
      endcase
      probe_valid = v; probe_in = p; ext_trig = e;
      if (v) begin
        smp.push_back(p);
        sts.push_back(tb_ts);
        if (n >= pt && trig < 0 && ((((p ^ value) & mask) == '0) || e)) trig = n;
        if (trig >= 0 && n == trig + D - pt - 1) complete = 1'b1;
      end
      cyc();
      check("busy", busy, !complete);
      check("triggered", triggered, trig >= 0);
    end
    idle_inputs();
    check("capture_in_budget", complete, 1);
    if (complete) begin
      check("done", done, 1);
      check("trig_addr", trig_addr, (wp0 + trig) % D);
      check("start_addr", start_addr, (wp0 + trig - pt) % D);
`ifdef TRACE_TIMESTAMP_EN
      check("trig_ts", trig_ts, sts[trig]);
`endif
      for (int i = 0; i < D; i++) begin
        rd_en = 1'b1; rd_addr = AW'(i);
        cyc();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, smp[trig - pt + i]);
`ifdef TRACE_TIMESTAMP_EN
        check("rd_ts", rd_ts, sts[trig - pt + i]);
`endif
      end
      rd_en = 1'b0;
      cyc();
      check("rd_valid_low", rd_valid, 0);
      prev_oldest = smp[trig - pt];
      have_prev = 1'b1;
    end
    wp_model = (wp0 + smp.size()) % D;
  endtask

  initial begin
    idle_inputs();
    probe_in = '0; trig_mask = '0; trig_value = '0; pretrig = '0; rd_addr = '0;
    rst_n = 1'b0; tb_ts = '0; wp_model = 0; have_prev = 1'b0; prev_oldest = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    check("rst_start_addr", start_addr, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
`ifdef TRACE_TIMESTAMP_EN
    check("rst_trig_ts", trig_ts, 0);
`endif

    // Counter on ch0, trigger on 5 with 4 pre-trigger entries.
    run_capture(0, 4, 16'h00FF, 16'h0005);
    check("t1_trig_addr", trig_addr, 5);
    check("t1_start_addr", start_addr, 1);

    // No pre-trigger, external trigger on 3rd valid sample.
    run_capture(3, 0, 16'hFFFF, 16'hFFFF);
    // Maximum pre-trigger depth: one post entry.
    run_capture(0, 15, 16'h00FF, 16'h000F);
    // Gapped probe_valid; matching values on invalid cycles must not trigger.
    run_capture(2, 2, 16'hFFFF, 16'h5A5A);

    for (int k = 0; k < 8; k++)
      run_capture(1, int'($urandom % 16), EW'($urandom) & 16'h0107, EW'($urandom));

    // Arm during POST is ignored, then reset mid-POST.
    trig_mask = '0; trig_value = '0; pretrig = AW'(2);
    arm = 1'b1; cyc(); arm = 1'b0;
    probe_valid = 1'b1; probe_in = 16'h1234;
    repeat (5) cyc();
    arm = 1'b1; cyc(); arm = 1'b0;
    check("post_arm_busy", busy, 1);
    check("post_arm_triggered", triggered, 1);
    check("post_arm_done", done, 0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    probe_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_triggered", triggered, 0);
    check("midrst_start_addr", start_addr, 0);
    check("midrst_trig_addr", trig_addr, 0);
    cyc();
    check("midrst_idle_busy", busy, 0);
    check("midrst_idle_done", done, 0);
    wp_model = 0; have_prev = 1'b0;
    // Write pointer restarts at 0 after the reset.
    run_capture(0, 4, 16'h00FF, 16'h0005);
    check("t5_trig_addr", trig_addr, 5);
    check("t5_start_addr", start_addr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
